// File: rtl/hazard_scoreboard.sv
// Interlock and forwarding-select unit for the in-order integer pipeline.
// Tracks in-flight destinations after ID and raises the bbl stall.
module hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int FWD_EN     = 1,
  parameter int LATE_STAGE = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [NUM_SRC-1:0]        id_re,
  input  logic [NUM_SRC*ADDR_W-1:0] id_raddr,
  input  logic                      id_we,
  input  logic [ADDR_W-1:0]         id_waddr,
  input  logic                      id_late,
  output logic                      bbl,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic [15:0]               stall_cnt
);

  logic [DEPTH-1:0]  v_q, v_d;
  logic [DEPTH-1:0]  late_q, late_d;
  logic [ADDR_W-1:0] wa_q [DEPTH];
  logic [ADDR_W-1:0] wa_d [DEPTH];
  logic [15:0]       cnt_q, cnt_d;
  logic              stall_any;
  logic              ld;

  // Per-source youngest-match search, readiness and select.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic              hl;
    logic [SEL_W-1:0]  hk;
    stall_any = 1'b0;
    fwd_sel   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ra  = id_raddr[i*ADDR_W +: ADDR_W];
      hit = 1'b0;
      hl  = 1'b0;
      hk  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (v_q[k] && wa_q[k] == ra) begin
          hit = 1'b1;
          hl  = late_q[k];
          hk  = SEL_W'(k);
        end
      end
      if (id_valid && id_re[i] && ra != '0 && hit) begin
        if (FWD_EN != 0) begin
          if (!hl || hk >= SEL_W'(LATE_STAGE))
            fwd_sel[i*SEL_W +: SEL_W] = hk + 1'b1;
          else
            stall_any = 1'b1;
        end else if (hk <= SEL_W'(DEPTH - 2)) begin
          stall_any = 1'b1;
        end
      end
    end
    if (rst) fwd_sel = '0;
  end

  assign bbl = stall_any & ~rst & ~flush;

  assign ld = id_valid & id_we & (id_waddr != '0)
            & ~bbl & ~flush;

  // Shift the entries one stage and load entry 0.
  always_comb begin
    v_d[0]    = ld;
    late_d[0] = id_late;
    wa_d[0]   = id_waddr;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]    = v_q[k-1];
      late_d[k] = late_q[k-1];
      wa_d[k]   = wa_q[k-1];
    end
    if (flush) v_d[1] = 1'b0;
    cnt_d = cnt_q;
    if (bbl && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Scoreboard and stall-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      late_q <= '0;
      cnt_q  <= '0;
      for (int k = 0; k < DEPTH; k++) wa_q[k] <= '0;
    end else begin
      v_q    <= v_d;
      late_q <= late_d;
      cnt_q  <= cnt_d;
      for (int k = 0; k < DEPTH; k++) wa_q[k] <= wa_d[k];
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised interlock and forwarding-control unit for the in-order integer pipeline. It tracks destination registers of in-flight instructions through a configurable number of post-decode stages. It raises the `bbl` stall consumed by `pc_reg` and `if_id`, and for each source operand of the instruction in ID it selects either the regfile or a pipeline stage as the forwarding source. It generalises the fixed two-read-port `exp_*`/`tar_addr` export to any number of source operands, any tracking depth, a stall-only or forwarding mode, and late-result (load-type) producers.

## Interface
- `NUM_SRC`, 2: source operands per instruction.
- `ADDR_W`, 5: register address width. Address 0 is never a hazard.
- `DEPTH`, 3: tracked stages after ID. Entry 0 = EX, entry DEPTH-1 = WB. Must be ≥2.
- `FWD_EN`, 1: 1 = forward when data is ready; 0 = stall-only.
- `LATE_STAGE`, 1: first entry index at which a late result is forwardable. Must satisfy 1 ≤ LATE_STAGE ≤ DEPTH-1.
- `SEL_W`, clog2(DEPTH+1): width of each forwarding select.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: squash the ID instruction and entry 0.
- `id_valid` in 1: ID holds a real instruction.
- `id_re` in NUM_SRC: per-source read enable.
- `id_raddr` in NUM_SRC*ADDR_W: source addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
- `id_we` in 1: the ID instruction writes a register.
- `id_waddr` in ADDR_W: destination address.
- `id_late` in 1: the result becomes available only at entry LATE_STAGE.
- `bbl` out 1: stall. Hold PC and IF/ID, and insert a bubble into ID/EX.
- `fwd_sel` out NUM_SRC*SEL_W: per-source select. 0 = regfile; k+1 = forward from entry k.
- `stall_cnt` out 16: saturating count of stall cycles.

## Operation
- Each scoreboard entry holds {v, waddr, late}. There are DEPTH entries.
- Every cycle the entries shift: entry k+1 ← entry k. The old entry DEPTH-1 is retired.
- Entry 0 loads the ID instruction when `id_valid & id_we & id_waddr≠0 & ~bbl & ~flush`. Otherwise entry 0 loads a bubble (v=0).
- `flush` zeroes the v bit of the value shifting into entry 1, which squashes the current entry 0. It also inserts a bubble at entry 0.
- Per source i, a match exists when `id_valid & id_re[i] & raddr_i≠0`. The selected entry is the lowest-index valid entry with waddr = raddr_i; the youngest producer wins.
- Readiness of matched entry k: ready if `~late | k ≥ LATE_STAGE`.
- When FWD_EN=1:
  - Matched and ready → `fwd_sel_i = k+1`, no stall from this source.
  - Matched and not ready → stall from this source.
  - The stall stands even if an older entry also matches and is ready.
- When FWD_EN=0:
  - Match at k ≤ DEPTH-2 → stall.
  - Match at k = DEPTH-1 → `fwd_sel_i = 0`; the regfile's same-cycle write bypass supplies the value.
  - `fwd_sel` is otherwise always 0.
- No match → `fwd_sel_i = 0`.
- `bbl` = OR of all per-source stalls, gated by `~rst & ~flush`.
- `stall_cnt` increments on each cycle with `bbl=1` and saturates at 16'hFFFF.

## Timing
- `bbl` and `fwd_sel` are combinational from the current entries and ID inputs, valid in the same cycle. There are no combinational paths from `bbl` back into match logic other than the entry-0 load gate.
- The scoreboard updates on the rising edge. A producer issued in cycle t occupies entry k during cycle t+1+k.
- A load followed immediately by a consumer, with LATE_STAGE=1, stalls exactly 1 cycle. The consumer's `fwd_sel` is then 2.
- Stall-only mode with DEPTH=3: a back-to-back dependency stalls 2 cycles. The consumer then reads from the regfile with `fwd_sel=0`.
- During a stall the ID inputs stay constant (IF/ID holds), and the producer advances one entry per cycle.
- Reset:
  - All entries have v=0.
  - `stall_cnt`=0.
  - `bbl`=0 and `fwd_sel`=0 while rst=1.
  - A reset mid-stall drops the stall on the same cycle.
- Simultaneous `flush` and a hazard: `flush` wins. `bbl`=0 and entry 0 is loaded as a bubble.
- If `id_waddr` equals one of its own sources, there is no self-hazard; only older entries are compared.

## Test plan
- Reset, then ADD r3 followed by SUB using r3 (FWD_EN=1, DEPTH=3) → `bbl`=0 and `fwd_sel` for r3 = 1 in the SUB cycle.
- LW r4 (late) followed by ADD using r4 → `bbl`=1 for exactly 1 cycle, then `fwd_sel`=2. `stall_cnt` goes 0→1.
- FWD_EN=0, ADD r5 followed by consumer of r5 → `bbl` high 2 cycles, then `fwd_sel`=0. `stall_cnt`=2.
- Two producers writing r6 (late entry 0, normal entry 1), then a consumer of r6 → stall, because the youngest producer wins. The next cycle gives `fwd_sel`=2.
- Writes to r0 and reads of r0 in any order → `bbl` never set, `fwd_sel`=0. Reads with `id_re`=0 likewise.
- Stall in progress, then assert `flush` → `bbl`=0 that cycle and entries 0 and 1 are invalid afterward. Assert `rst` mid-stall → all outputs 0 and `stall_cnt`=0 next cycle.
